// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the sub-word data memory.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic {CLEAR, RUN} state_t;

   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Store byte-enable/data replication and load lane extraction with sign/zero extension.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   // Little-endian: lane 0 is bits [7:0]; shift the selected lane down to bit 0.
   assign shifted = rword >> {lane, 3'b000};

   always_comb begin
      be    = 4'b0000;
      wword = 32'h0;
      rdata = 32'h0;
      case (size)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wword = {4{wdata[7:0]}};
            rdata = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            be    = 4'b0011 << lane;
            wword = {2{wdata[15:0]}};
            rdata = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
         end
         SZ_WORD: begin
            be    = 4'b1111;
            wword = wdata;
            rdata = rword;
         end
         SZ_ILL: begin
            be    = 4'b0000;
         end
         default: begin
            be    = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/dmem_subword.sv
// Data memory with byte/half/word access, clear sweep after reset and RD_LAT response pipe.
// Optional DMEM_STAT_EN adds accepted-load/store/error counters.
module dmem_subword
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = 512,
   parameter int unsigned RD_LAT    = 1,
   parameter logic [31:0] CLR_VALUE = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        init_busy
`ifdef DMEM_STAT_EN
   ,
   output logic [31:0] stat_rd_cnt,
   output logic [31:0] stat_wr_cnt,
   output logic [31:0] stat_err_cnt
`endif
);

   localparam int unsigned IW = idx_width(DEPTH);

   state_t          state_q, state_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic            clr_we;
   logic [31:0]     mem [DEPTH];

   logic            accept, req_err, st_we, ld_ok;
   logic [IW-1:0]   idx;
   logic [31:0]     rword, wword, ld_data;
   logic [3:0]      be;

   logic [RD_LAT-1:0] pv_q;
   logic [31:0]       pd_q [RD_LAT];
   logic [RD_LAT-1:0] pe_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clr_we    = 1'b0;
      req_ready = 1'b0;
      init_busy = 1'b0;
      case (state_q)
         CLEAR: begin
            init_busy = 1'b1;
            clr_we    = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == IW'(DEPTH - 1)) state_d = RUN;
         end
         RUN: req_ready = 1'b1;
         default: state_d = CLEAR;
      endcase
   end

   assign accept = req_valid & req_ready;
   assign idx    = req_addr[IW+1:2];
   assign rword  = mem[idx];

   always_comb begin
      case (req_size)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = |req_addr[1:0];
         default: req_err = 1'b1;
      endcase
      // Anything at or above 4*DEPTH has a nonzero bit above the index field.
      req_err = req_err | (|req_addr[31:IW+2]);
   end

   assign st_we = accept & req_wr & ~req_err;
   assign ld_ok = accept & ~req_wr & ~req_err;

   dmem_lane_fmt u_lane_fmt (
      .size        (req_size),
      .ld_unsigned (req_unsigned),
      .lane        (req_addr[1:0]),
      .wdata       (req_wdata),
      .rword       (rword),
      .be          (be),
      .wword       (wword),
      .rdata       (ld_data)
   );

   // Array has no reset; contents are rebuilt by the clear sweep.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[cnt_q] <= CLR_VALUE;
      end else if (st_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pv_q <= '0;
         pe_q <= '0;
         for (int i = 0; i < RD_LAT; i++) pd_q[i] <= 32'h0;
      end else begin
         pv_q[0] <= accept;
         pe_q[0] <= accept & req_err;
         pd_q[0] <= ld_ok ? ld_data : 32'h0;
         for (int i = 1; i < RD_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pe_q[i] <= pe_q[i-1];
            pd_q[i] <= pd_q[i-1];
         end
      end
   end

   assign rsp_valid = pv_q[RD_LAT-1];
   assign rsp_err   = pe_q[RD_LAT-1];
   assign rsp_rdata = pd_q[RD_LAT-1];

`ifdef DMEM_STAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_rd_cnt  <= 32'h0;
         stat_wr_cnt  <= 32'h0;
         stat_err_cnt <= 32'h0;
      end else begin
         if (ld_ok)            stat_rd_cnt  <= stat_rd_cnt + 32'd1;
         if (st_we)            stat_wr_cnt  <= stat_wr_cnt + 32'd1;
         if (accept & req_err) stat_err_cnt <= stat_err_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_subword.sv
// Directed bench for dmem_subword with an in-order response scoreboard.
module tb_dmem_subword;
   import dmem_pkg::*;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned RD_LAT = 3;
   localparam logic [31:0] CLR    = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_wr, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_err, init_busy;
   logic [31:0] rsp_rdata;
`ifdef DMEM_STAT_EN
   logic [31:0] stat_rd_cnt, stat_wr_cnt, stat_err_cnt;
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   dmem_subword #(
      .DEPTH     (DEPTH),
      .RD_LAT    (RD_LAT),
      .CLR_VALUE (CLR)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wr       (req_wr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .init_busy    (init_busy)
`ifdef DMEM_STAT_EN
      ,
      .stat_rd_cnt  (stat_rd_cnt),
      .stat_wr_cnt  (stat_wr_cnt),
      .stat_err_cnt (stat_err_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge and matched against the scoreboard.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      #1;
      if (rsp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
         end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk("missing_rsp", 32'(rsp_valid), 32'd1);
      end
   endtask

   task automatic req(input logic wr, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input bit push);
      req_valid    = 1'b1;
      req_wr       = wr;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      if (push) sb.push_back('{rdata: exp_rdata, err: exp_err, cyc: cyc + RD_LAT});
      tick();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (RD_LAT + 2) tick();
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic sweep_check();
      int n = 0;
      while (init_busy === 1'b1 && n < 100) begin
         chk("ready_low_in_clear", 32'(req_ready), 32'd0);
         tick();
         n++;
      end
      chk("sweep_cycles", 32'(n), 32'(DEPTH));
      chk("ready_after_sweep", 32'(req_ready), 32'd1);
   endtask

   initial begin
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_wr       = 1'b0;
      req_size     = SZ_WORD;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      repeat (2) tick();
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_init_busy", 32'(init_busy), 32'd1);

      // Requests offered during the sweep must be ignored.
      reset     = 1'b0;
      req_valid = 1'b1;
      sweep_check();
      req_valid = 1'b0;

      req(1'b0, SZ_WORD, 1'b0, 32'h3C, 32'h0, CLR, 1'b0, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, CLR, 1'b0, 1'b1);
      req(1'b1, SZ_WORD, 1'b0, 32'h08, 32'h1122_3344, 32'h0, 1'b0, 1'b1);
      req(1'b0, SZ_BYTE, 1'b1, 32'h09, 32'h0, 32'h0000_0033, 1'b0, 1'b1);
      req(1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0, 32'h0000_1122, 1'b0, 1'b1);
      req(1'b1, SZ_BYTE, 1'b0, 32'h0B, 32'h1234_5680, 32'h0, 1'b0, 1'b1);
      req(1'b0, SZ_BYTE, 1'b0, 32'h0B, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 32'h8022_3344, 1'b0, 1'b1);
      req(1'b0, SZ_HALF, 1'b0, 32'h0A, 32'h0, 32'hFFFF_8022, 1'b0, 1'b1);
      req(1'b0, SZ_HALF, 1'b1, 32'h0A, 32'h0, 32'h0000_8022, 1'b0, 1'b1);
      req(1'b0, SZ_BYTE, 1'b1, 32'h08, 32'h0, 32'h0000_0044, 1'b0, 1'b1);
      req(1'b1, SZ_HALF, 1'b0, 32'h0E, 32'h1234_ABCD, 32'h0, 1'b0, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, 32'hABCD_BEEF, 1'b0, 1'b1);
      drain();

      // Error cases: none may write the array.
      req(1'b1, SZ_HALF, 1'b0, 32'h03, 32'h0000_AAAA, 32'h0, 1'b1, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0, CLR, 1'b0, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0, 1'b1, 1'b1);
      req(1'b0, SZ_ILL,  1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1'b1);
      req(1'b1, SZ_WORD, 1'b0, 32'h44, 32'h5555_5555, 32'h0, 1'b1, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0, CLR, 1'b0, 1'b1);
      drain();

      req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
      drain();

      // Reset with a store response in flight: it must be discarded and memory re-cleared.
      req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h55AA_55AA, 32'h0, 1'b0, 1'b0);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      reset     = 1'b1;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_init_busy", 32'(init_busy), 32'd1);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      repeat (RD_LAT + 1) tick();
      chk("midrst_busy_held", 32'(init_busy), 32'd1);
      reset     = 1'b0;
      req_valid = 1'b0;
      sweep_check();

      req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, CLR, 1'b0, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, CLR, 1'b0, 1'b1);
      req(1'b1, SZ_BYTE, 1'b0, 32'h20, 32'h0000_007F, 32'h0, 1'b0, 1'b1);
      req(1'b1, SZ_WORD, 1'b0, 32'h24, 32'h0102_0304, 32'h0, 1'b0, 1'b1);
      req(1'b1, SZ_HALF, 1'b0, 32'h21, 32'h0000_FFFF, 32'h0, 1'b1, 1'b1);
      req(1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 32'hDEAD_BE7F, 1'b0, 1'b1);
      drain();
`ifdef DMEM_STAT_EN
      chk("stat_rd_cnt", stat_rd_cnt, 32'd3);
      chk("stat_wr_cnt", stat_wr_cnt, 32'd2);
      chk("stat_err_cnt", stat_err_cnt, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_subword.md
Name: dmem_subword

Overview:
- Parametrised data memory for the pipelined CPU's MEM stage.
- Successor to the fixed-latency word-only data RAM.
- Adds byte/halfword loads and stores (sign/zero extension, little-endian), a valid/ready request port and configurable read latency.
- Adds alignment/range error reporting and a hardware clear sweep after reset instead of a one-cycle array reset.

Parameters:
- DEPTH, 512, number of 32-bit words; power of two, 16..65536.
- RD_LAT, 1, cycles from request acceptance to response; 1..4.
- CLR_VALUE, 32'h0, word written to every location by the clear sweep.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts request this cycle.
- req_wr  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  response pulse, one per accepted request.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal size or out-of-range.
- init_busy  out  1  clear sweep in progress.

Behaviour:
- Reset values:
  - State CLEAR, sweep counter 0, latency pipe empty.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1.
- FSM CLEAR:
  - Writes CLR_VALUE to word[cnt] each cycle; cnt increments.
  - At cnt==DEPTH-1 the write completes and the FSM moves to RUN next cycle.
  - Sweep takes exactly DEPTH cycles after reset deassert.
  - req_ready=0 throughout.
- FSM RUN:
  - init_busy=0, req_ready=1 every cycle (no backpressure).
  - Accept occurs when req_valid and req_ready are both high on a rising edge.
- Word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0].
- Error conditions, checked at accept:
  - size 11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - req_addr >= 4*DEPTH.
- On error: no array write; response carries err=1, rdata=0.
- Store:
  - Byte: writes req_wdata[7:0] into lane byte.
  - Half: writes req_wdata[15:0] into bytes lane, lane+1.
  - Word: writes all 4 bytes.
  - Other bytes are unchanged.
  - Commits at the accept edge.
- Load:
  - Array word is sampled at the accept edge, before that edge's own write (a load and store cannot share a cycle).
  - Selected byte/half is shifted to bits [7:0]/[15:0] and sign- or zero-extended per req_unsigned.
- Latency:
  - Response appears exactly RD_LAT cycles after accept, in order, fully pipelined (one response per cycle sustained).
  - Store responses: rsp_valid=1, rdata=0, err per check.
- Back-to-back: a load issued the cycle after a store to the same word returns the stored data.
- Reset mid-operation: all in-flight responses are discarded (rsp_valid forced 0) and the FSM re-enters CLEAR; memory contents are re-cleared.
- req_valid during CLEAR is ignored and produces no response.

Optional Feature:
- Macro: DMEM_STAT_EN.
- When defined, adds outputs stat_rd_cnt[31:0], stat_wr_cnt[31:0] and stat_err_cnt[31:0]:
  - Counters increment on each accepted non-error load, non-error store and error request respectively.
  - All wrap at 2^32 and reset to 0.
  - They do not count during CLEAR.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dmem_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL.
  - FSM state type {CLEAR, RUN}.
  - Function computing the log2 index width.
- One natural sub-module: dmem_lane_fmt, the combinational store byte-enable/data alignment plus load extraction/extension.
- The core holds the array, FSM and latency pipe.

Test Plan:
- Reset, DEPTH=16 -> init_busy high exactly 16 cycles, req_ready rises on cycle 17; load addr 0x3C returns CLR_VALUE.
- Store word 0x11223344 @0x8, then loads:
  - byte-unsigned @0x9 -> 0x00000033.
  - half-signed @0xA -> 0x00001122.
  - byte-signed after storing 0x80 @0xB -> 0xFFFFFF80.
- Half store @0x3 -> rsp_err=1, rdata=0, word unchanged; word load @0x4*DEPTH -> rsp_err=1.
- RD_LAT=3, four consecutive loads on cycles N..N+3 -> rsp_valid on N+3..N+6, data in order.
- Store @0x10 cycle N, load @0x10 cycle N+1 -> new data returned; assert reset at N+1 -> no rsp_valid, init_busy=1 next cycle, sweep restarts.
- DMEM_STAT_EN: 3 loads, 2 stores, 1 misaligned -> stat_rd_cnt=3, stat_wr_cnt=2, stat_err_cnt=1.
